// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for adder_tree_sched: operand-set input channel and
// reduction-result output channel. W is the operand width.
interface adder_tree_sched_if #(
  parameter int W = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [8*W-1:0]   in_ops;
  logic             out_valid;
  logic             out_ready;
  logic [W+2:0]     out_sum;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_ops, out_ready,
    input  in_ready, out_valid, out_sum
  );

  // Reduction engine side
  modport slave (
    input  in_valid, in_ops, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: reduces eight unsigned W-bit operands to one W+3-bit sum
// using a single shared two-input adder, one addition per ADD cycle:
//   s0 p0=op0+op1  s1 p1=op2+op3  s2 p2=op4+op5  s3 p3=op6+op7
//   s4 q0=p0+p1    s5 q1=p2+p3    s6 sum=q0+q1
// Optional feature macro ADDER_SCHED_2_LEVEL_EN: run only s0, s1, s4 and
// return op0+op1+op2+op3 (op4..op7 ignored).
module adder_tree_sched #(
  parameter int ADDER_WIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  output logic              busy,
  adder_tree_sched_if.slave bus
);
  localparam int W  = ADDER_WIDTH;
  localparam int SW = W + 3;

`ifdef ADDER_SCHED_2_LEVEL_EN
  localparam logic [2:0] LAST_STEP = 3'd4;
`else
  localparam logic [2:0] LAST_STEP = 3'd6;
`endif

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      step_reg, step_next;
  logic [W-1:0]    op_reg [8];
  logic [W:0]      p_reg  [4];
  logic [W+1:0]    q_reg  [2];
  logic [SW-1:0]   sum_reg;
  logic [SW-1:0]   add_a, add_b, add_sum;
  logic            accept;
  logic            add_en;

  // An operand set is taken only in IDLE; abort wins over the accept.
  assign accept = (state_reg == IDLE) && bus.in_valid && !abort;
  // Datapath updates are suppressed on an aborting edge so out_sum keeps its value.
  assign add_en = (state_reg == ADD) && !abort;

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_sum   = sum_reg;
  assign busy          = (state_reg != IDLE);

  // State and step counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  // Next-state and step sequencing; abort forces IDLE from any state
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = ADD;
          step_next  = 3'd0;
        end
      end
      ADD: begin
        if (step_reg == LAST_STEP) begin
          state_next = DONE;
        end else begin
`ifdef ADDER_SCHED_2_LEVEL_EN
          step_next = (step_reg == 3'd1) ? 3'd4 : step_reg + 3'd1;
`else
          step_next = step_reg + 3'd1;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Operand capture, one register per lane, written only on accept
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_op
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_reg[gi] <= '0;
        else if (accept) op_reg[gi] <= bus.in_ops[gi*W +: W];
      end
    end
  endgenerate

  // Shared adder input selection by step; narrower partials zero-extended
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (step_reg)
      3'd0: begin add_a = {3'b000, op_reg[0]}; add_b = {3'b000, op_reg[1]}; end
      3'd1: begin add_a = {3'b000, op_reg[2]}; add_b = {3'b000, op_reg[3]}; end
      3'd2: begin add_a = {3'b000, op_reg[4]}; add_b = {3'b000, op_reg[5]}; end
      3'd3: begin add_a = {3'b000, op_reg[6]}; add_b = {3'b000, op_reg[7]}; end
      3'd4: begin add_a = {2'b00, p_reg[0]};   add_b = {2'b00, p_reg[1]};   end
      3'd5: begin add_a = {2'b00, p_reg[2]};   add_b = {2'b00, p_reg[3]};   end
      3'd6: begin add_a = {1'b0, q_reg[0]};    add_b = {1'b0, q_reg[1]};    end
      default: ;
    endcase
  end

  assign add_sum = add_a + add_b;

  // Partial and result registers, each written by its own step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg[0] <= '0;
      p_reg[1] <= '0;
      p_reg[2] <= '0;
      p_reg[3] <= '0;
      q_reg[0] <= '0;
      q_reg[1] <= '0;
      sum_reg  <= '0;
    end else if (add_en) begin
      case (step_reg)
        3'd0: p_reg[0] <= add_sum[W:0];
        3'd1: p_reg[1] <= add_sum[W:0];
        3'd2: p_reg[2] <= add_sum[W:0];
        3'd3: p_reg[3] <= add_sum[W:0];
        3'd4: begin
          q_reg[0] <= add_sum[W+1:0];
`ifdef ADDER_SCHED_2_LEVEL_EN
          sum_reg  <= add_sum;
`endif
        end
        3'd5: q_reg[1] <= add_sum[W+1:0];
        3'd6: sum_reg  <= add_sum;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 14: operand width W in bits.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port abort  input  1: synchronous cancel of the current job.
REQ-005 SHALL have port in_valid  input  1: operand set offered.
REQ-006 SHALL have port in_ready  output  1: block can accept an operand set.
REQ-007 SHALL have port in_ops  input  8*W: operand k at bits [k*W +: W], k=0..7, unsigned.
REQ-008 SHALL have port out_valid  output  1: out_sum valid.
REQ-009 SHALL have port out_ready  input  1: consumer accepts out_sum.
REQ-010 SHALL have port out_sum  output  W+3: reduction result, unsigned.
REQ-011 SHALL have port busy  output  1: high in ADD or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, ADD, DONE, using exactly one shared two-input adder for all additions.
REQ-013 SHALL assert in_ready only in IDLE, decoded from state.
REQ-014 SHALL, on an edge with in_valid=1 and in_ready=1 (cycle t), register all 8 operands, clear step counter to 0, and enter ADD.
REQ-015 SHALL perform one addition per ADD cycle in this fixed order: s0 p0=op0+op1; s1 p1=op2+op3; s2 p2=op4+op5; s3 p3=op6+op7; s4 q0=p0+p1; s5 q1=p2+p3; s6 s=q0+q1.
REQ-016 SHALL size partials as p: W+1, q: W+2, s: W+3 bits, zero-extended into the shared adder; no overflow is possible.
REQ-017 SHALL enter DONE after the final step, so out_valid is high from cycle t+8 (7 ADD cycles) with out_sum registered.
REQ-018 SHALL hold out_sum and out_valid stable in DONE while out_ready=0, indefinitely.
REQ-019 SHALL, on an edge in DONE with out_ready=1, return to IDLE; out_valid drops and in_ready rises the next cycle; minimum period is 9 cycles per job.
REQ-020 SHALL ignore in_valid and in_ops outside IDLE; operand registers are not overwritten mid-job.
REQ-021 SHALL, on abort=1 in any state, go to IDLE on that edge, dropping any result; abort has priority over accept and out handshake.
REQ-022 SHALL keep out_sum at its last value outside DONE; it is only meaningful while out_valid=1.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, step counter 0, out_valid 0, out_sum 0, busy 0, and clear all operand/partial registers to 0; in_ready=1 once rst_n releases.
REQ-024 SHALL, on reset during ADD or DONE, abandon the job with no out_valid pulse after release.

Configuration
REQ-025 SHALL support macro ADDER_SCHED_2_LEVEL_EN.
REQ-026 With the macro defined, ADD SHALL run only steps s0, s1, s4 (3 cycles): out_sum = zero-extended op0+op1+op2+op3, op4..op7 ignored, out_valid from cycle t+4.
REQ-027 With the macro undefined, the full 7-step, 8-operand schedule of REQ-015 SHALL apply.

Verification
REQ-028 All ops=1, out_ready=1 -> out_sum=8 at cycle t+8 (2-level: 4 at t+4), out_valid high for one cycle.
REQ-029 All ops=16383 (W=14) -> out_sum=131064 (2-level: 65532); no truncation.
REQ-030 op k=k -> out_sum=28 (2-level: 6); then a new job with op k=100 accepted on the first IDLE cycle -> 800.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_sum stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 rst_n low during step s3 -> out_valid=0, out_sum=0, in_ready=1 after release; next job of all-2 operands -> 16.
REQ-033 abort in ADD step s5, and separately in DONE with out_ready=1 -> IDLE next cycle, no further out_valid; in_valid held in IDLE is accepted on the following edge.
